centroid_moment_accumulator: RTL
================================

# centroid_moment_accumulator

Consumes the 18 signed, distance-weighted row differences produced by the centroid multiplier stage and reduces them to one ORB intensity-centroid moment (m01 or m10) per keypoint patch. Each cycle it sums one patch row of weighted differences through a pipelined adder tree, then accumulates that row sum over `N_ROWS` rows. It presents the finished moment with a one-cycle valid pulse to the orientation (atan2) stage. One instance serves each moment axis.

## Interface
- `BW_IN`, 14: width of each signed weighted-difference input.
- `BW_ROW`, 17: signed row-sum width; covers |255·(1+…+18)| = 43605.
- `BW_ACC`, 22: signed moment width; covers 37·43605 = 1,613,385.
- `N_ROWS`, 37: rows per patch.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  **synchronous, active-low reset.**
- `ena`  in  1  global pipeline enable. When low, every register in the block holds.
- `in_valid`  in  1  `in1..in18` carry one valid patch row this cycle.
- `in_first`  in  1  qualified by `in_valid`; marks row 0 of a patch.
- `in1..in18`  in  `BW_IN` each  signed weighted differences, weights 1..18.
- `out_moment`  out  `BW_ACC`  signed accumulated moment.
- `out_valid`  out  1  one-cycle pulse; `out_moment` is final.
- `out_err`  out  1  one-cycle pulse; the current patch was aborted or a stray row was dropped.
- `busy`  out  1  high while a patch is being accumulated.

## Operation
- **Pipeline stages** (each advances only when `ena` is 1):
  - S1: register 9 pairwise sums (in1+in2, …, in17+in18), each `BW_IN`+1 bits, with a valid bit and a last-row bit.
  - S2: register the total row sum, sign-extended to `BW_ROW`.
  - S3: accumulator. `acc <= first ? rowsum : acc + rowsum`, sign-extended to `BW_ACC`. No saturation is needed; the widths are exact.
- **Row counter:** `row_cnt`, 0..`N_ROWS`-1, lives at the input side and is tagged down the pipe.
- **FSM** (input side): IDLE, ACCUM.
  - IDLE: `in_valid & in_first` → ACCUM, `row_cnt` = 1.
  - IDLE: `in_valid & ~in_first` → row dropped, `out_err` pulse 3 cycles later.
  - ACCUM: `in_valid & ~in_first` → `row_cnt`++. When the accepted row is row `N_ROWS`-1, tag it last and return to IDLE.
  - ACCUM: `in_valid & in_first` → the partial patch is aborted. The new row starts a fresh patch (`row_cnt` = 1, stay in ACCUM). `out_err` pulses when the new first row reaches S3.
- `N_ROWS`=1 is legal: the first row is also the last row.
- `busy` = (state == ACCUM) OR any S1/S2/S3 valid bit set.
- **Reset values:** `out_moment`=0, `out_valid`=0, `out_err`=0, `busy`=0, state IDLE, `row_cnt`=0, all valid bits 0. Reset mid-patch discards all partial state; no `out_valid` is produced for that patch.

## Timing
- Row accepted at cycle t (with `ena` high throughout) → S1 at t+1, S2 at t+2, accumulator at t+3.
- Last row accepted at t → `out_valid`=1 for exactly the cycle after edge t+3, with the final `out_moment`.
- `out_moment` holds its value until the next completion.
- `ena` low freezes all stages, including the `out_valid` and `out_err` pulse registers.
- Rows may arrive back-to-back. A new patch's first row may be accepted in the same cycle the previous patch's last row is still in S1/S2. Each row's tag keeps the two patches separate, with no bubble required.
- `in_valid` low: no state change except the pipeline draining.

## Structure
- Package `orb_pkg`: `BW_IN`, `BW_ROW`, `BW_ACC`, `N_ROWS` defaults, the FSM state typedef, and the typedef for the row tag (valid, first, last).
- Sub-module `centroid_row_adder`: S1+S2 adder tree with its valid/tag pipeline, 2-cycle latency, honouring `ena`. The top level holds the FSM, the row counter and S3.

## Test plan
- **Unit rows:** all inputs = 1, 37 back-to-back rows → `out_valid` 3 cycles after the last row, `out_moment` = 666, `out_err` never high.
- **Extreme positive:** `in_k` = 255·k for all rows → `out_moment` = 1,613,385. With `in_k` = −255·k → `out_moment` = −1,613,385.
- **Abort:** `in_first` reasserted at row 10 → `out_err` pulse; the final result reflects only the new patch's 37 rows.
- **Stall:** `ena` low for 5 cycles mid-patch and once during the `out_valid` cycle → the result is identical and the pulse is extended by the stall only.
- **Reset:** `rst` low at row 20 then released, followed by a full patch of value 2 → `out_moment` = 1332. No output is produced for the interrupted patch.
- **Stray and back-to-back:** a stray `in_valid` without `in_first` in IDLE → `out_err`, no `out_valid`. Two back-to-back patches → two correct `out_valid` pulses 37 cycles apart.

Source files
------------

// File: rtl/orb_pkg.sv
// Shared widths, FSM states and the per-row tag for the ORB centroid moment path.
package orb_pkg;

  localparam int DEF_BW_IN  = 14;
  localparam int DEF_BW_ROW = 17;
  localparam int DEF_BW_ACC = 22;
  localparam int DEF_N_ROWS = 37;

  localparam int N_IN   = 18;
  localparam int N_PAIR = 9;

  typedef enum logic {
    ST_IDLE,
    ST_ACCUM
  } state_t;

  // err travels with the row that caused it; a dropped stray row carries err with valid low
  typedef struct packed {
    logic valid;
    logic first;
    logic last;
    logic err;
  } row_tag_t;

  function automatic int cntWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/centroid_row_adder.sv
// Two-stage adder tree: nine pairwise sums, then the full row sum, with the row tag
// carried alongside so every stage stays aligned with its data.
module centroid_row_adder
  import orb_pkg::*;
#(
  parameter int BW_IN  = DEF_BW_IN,
  parameter int BW_ROW = DEF_BW_ROW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  row_tag_t                 i_tag,
  input  logic signed [BW_IN-1:0]  i_row [N_IN],
  output logic signed [BW_ROW-1:0] o_sum,
  output row_tag_t                 o_tag,
  output logic                     o_s1Valid
);

  localparam int BW_PAIR = BW_IN + 1;

  logic signed [BW_PAIR-1:0] r_pair [N_PAIR];
  row_tag_t                  r_tag1;
  row_tag_t                  r_tag2;
  logic signed [BW_ROW-1:0]  r_sum;
  logic signed [BW_ROW-1:0]  w_total;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < N_PAIR; k++) begin
        r_pair[k] <= '0;
      end
      r_tag1 <= '0;
    end else if (ena) begin
      for (int k = 0; k < N_PAIR; k++) begin
        r_pair[k] <= BW_PAIR'(i_row[2*k]) + BW_PAIR'(i_row[2*k+1]);
      end
      r_tag1 <= i_tag;
    end
  end

  always_comb begin
    w_total = '0;
    for (int k = 0; k < N_PAIR; k++) begin
      w_total = w_total + BW_ROW'(r_pair[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sum  <= '0;
      r_tag2 <= '0;
    end else if (ena) begin
      r_sum  <= w_total;
      r_tag2 <= r_tag1;
    end
  end

  assign o_sum     = r_sum;
  assign o_tag     = r_tag2;
  assign o_s1Valid = r_tag1.valid;

endmodule

// File: rtl/centroid_moment_accumulator.sv
// Reduces one patch of weighted row differences to a single signed centroid moment.
// The input-side FSM tags each row; the accumulator trusts only the tags.
module centroid_moment_accumulator
  import orb_pkg::*;
#(
  parameter int BW_IN  = DEF_BW_IN,
  parameter int BW_ROW = DEF_BW_ROW,
  parameter int BW_ACC = DEF_BW_ACC,
  parameter int N_ROWS = DEF_N_ROWS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic                     in_valid,
  input  logic                     in_first,
  input  logic signed [BW_IN-1:0]  in1,
  input  logic signed [BW_IN-1:0]  in2,
  input  logic signed [BW_IN-1:0]  in3,
  input  logic signed [BW_IN-1:0]  in4,
  input  logic signed [BW_IN-1:0]  in5,
  input  logic signed [BW_IN-1:0]  in6,
  input  logic signed [BW_IN-1:0]  in7,
  input  logic signed [BW_IN-1:0]  in8,
  input  logic signed [BW_IN-1:0]  in9,
  input  logic signed [BW_IN-1:0]  in10,
  input  logic signed [BW_IN-1:0]  in11,
  input  logic signed [BW_IN-1:0]  in12,
  input  logic signed [BW_IN-1:0]  in13,
  input  logic signed [BW_IN-1:0]  in14,
  input  logic signed [BW_IN-1:0]  in15,
  input  logic signed [BW_IN-1:0]  in16,
  input  logic signed [BW_IN-1:0]  in17,
  input  logic signed [BW_IN-1:0]  in18,
  output logic signed [BW_ACC-1:0] out_moment,
  output logic                     out_valid,
  output logic                     out_err,
  output logic                     busy
);

  localparam int              CNT_W    = cntWidth(N_ROWS);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(N_ROWS - 1);
  localparam bit              ONE_ROW  = (N_ROWS == 1);

  logic signed [BW_IN-1:0]  w_row [N_IN];
  state_t                   r_state;
  state_t                   w_stateNext;
  logic [CNT_W-1:0]         r_rowCnt;
  logic [CNT_W-1:0]         w_rowCntNext;
  row_tag_t                 w_tagIn;
  row_tag_t                 w_rowTag;
  logic signed [BW_ROW-1:0] w_rowSum;
  logic                     w_s1Valid;
  logic signed [BW_ACC-1:0] w_rowExt;
  logic signed [BW_ACC-1:0] w_accNext;
  logic signed [BW_ACC-1:0] r_acc;
  logic signed [BW_ACC-1:0] r_moment;
  logic                     r_s3Valid;
  logic                     r_outValid;
  logic                     r_outErr;

  assign w_row[0]  = in1;
  assign w_row[1]  = in2;
  assign w_row[2]  = in3;
  assign w_row[3]  = in4;
  assign w_row[4]  = in5;
  assign w_row[5]  = in6;
  assign w_row[6]  = in7;
  assign w_row[7]  = in8;
  assign w_row[8]  = in9;
  assign w_row[9]  = in10;
  assign w_row[10] = in11;
  assign w_row[11] = in12;
  assign w_row[12] = in13;
  assign w_row[13] = in14;
  assign w_row[14] = in15;
  assign w_row[15] = in16;
  assign w_row[16] = in17;
  assign w_row[17] = in18;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_rowCnt <= '0;
    end else if (ena) begin
      r_state  <= w_stateNext;
      r_rowCnt <= w_rowCntNext;
    end
  end

  // A first row always opens a fresh patch; if one was already open it is flagged as aborted
  always_comb begin
    w_stateNext  = r_state;
    w_rowCntNext = r_rowCnt;
    w_tagIn      = '0;
    if (in_valid) begin
      if (in_first) begin
        w_tagIn.valid = 1'b1;
        w_tagIn.first = 1'b1;
        w_tagIn.last  = ONE_ROW;
        w_tagIn.err   = (r_state == ST_ACCUM);
        if (ONE_ROW) begin
          w_stateNext  = ST_IDLE;
          w_rowCntNext = '0;
        end else begin
          w_stateNext  = ST_ACCUM;
          w_rowCntNext = CNT_W'(1);
        end
      end else if (r_state == ST_ACCUM) begin
        w_tagIn.valid = 1'b1;
        if (r_rowCnt == LAST_ROW) begin
          w_tagIn.last = 1'b1;
          w_stateNext  = ST_IDLE;
          w_rowCntNext = '0;
        end else begin
          w_rowCntNext = r_rowCnt + CNT_W'(1);
        end
      end else begin
        w_tagIn.err = 1'b1;
      end
    end
  end

  centroid_row_adder #(
    .BW_IN  (BW_IN),
    .BW_ROW (BW_ROW)
  ) u_rowAdder (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .i_tag     (w_tagIn),
    .i_row     (w_row),
    .o_sum     (w_rowSum),
    .o_tag     (w_rowTag),
    .o_s1Valid (w_s1Valid)
  );

  always_comb begin
    w_rowExt  = BW_ACC'(w_rowSum);
    w_accNext = w_rowTag.first ? w_rowExt : r_acc + w_rowExt;
  end

  // out_moment is a separate register so it holds while the next patch accumulates
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_acc      <= '0;
      r_moment   <= '0;
      r_s3Valid  <= 1'b0;
      r_outValid <= 1'b0;
      r_outErr   <= 1'b0;
    end else if (ena) begin
      r_s3Valid  <= w_rowTag.valid;
      r_outValid <= w_rowTag.valid & w_rowTag.last;
      r_outErr   <= w_rowTag.err;
      if (w_rowTag.valid) begin
        r_acc <= w_accNext;
        if (w_rowTag.last) begin
          r_moment <= w_accNext;
        end
      end
    end
  end

  assign out_moment = r_moment;
  assign out_valid  = r_outValid;
  assign out_err    = r_outErr;
  assign busy       = (r_state == ST_ACCUM) | w_s1Valid | w_rowTag.valid | r_s3Valid;

endmodule
